// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the program counter, drives the program ROM
// address combinationally and registers each returned instruction into an
// output instruction register with a valid/ready handshake. Supports branch
// redirects (flush), stall on backpressure, run gating and either
// wrap-around or halt-at-end sequencing.
module instr_fetch_unit #(
   parameter int unsigned ADDR_W      = 4,
   parameter int unsigned INST_W      = 16,
   parameter int unsigned RESET_PC    = 0,
   parameter bit          STOP_AT_END = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [INST_W-1:0] rom_inst,
   output logic [INST_W-1:0] ir,
   output logic [ADDR_W-1:0] ir_pc,
   output logic              ir_valid,
   input  logic              ir_ready,
   input  logic              redir_valid,
   input  logic [ADDR_W-1:0] redir_addr,
   output logic              halted
);

   typedef enum logic [0:0] {
      S_FETCH = 1'b0,
      S_HALT  = 1'b1
   } state_e;

   localparam logic [ADDR_W-1:0] RESET_PC_C = ADDR_W'(RESET_PC);
   localparam logic [ADDR_W-1:0] PC_LAST    = {ADDR_W{1'b1}};
   localparam logic [ADDR_W-1:0] PC_ONE     = ADDR_W'(1);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [INST_W-1:0] ir_q, ir_d;
   logic [ADDR_W-1:0] ir_pc_q, ir_pc_d;
   logic              ir_valid_q, ir_valid_d;
   logic              halted_q, halted_d;
   logic              transfer_s;
   logic              slot_free_s;

   // State register with synchronous reset; reset discards any pending ir.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_FETCH;
         pc_q       <= RESET_PC_C;
         ir_q       <= {INST_W{1'b0}};
         ir_pc_q    <= {ADDR_W{1'b0}};
         ir_valid_q <= 1'b0;
         halted_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         ir_q       <= ir_d;
         ir_pc_q    <= ir_pc_d;
         ir_valid_q <= ir_valid_d;
         halted_q   <= halted_d;
      end
   end

   // Next-state logic: redirect beats fetch, fetch beats drain/stall.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      ir_d        = ir_q;
      ir_pc_d     = ir_pc_q;
      ir_valid_d  = ir_valid_q;
      halted_d    = halted_q;
      transfer_s  = ir_valid_q && ir_ready;
      slot_free_s = !ir_valid_q || ir_ready;

      case (state_q)
         S_FETCH: begin
            if (redir_valid) begin
               // Flush: the pending ir is dropped even if it is being accepted.
               pc_d       = redir_addr;
               ir_valid_d = 1'b0;
            end else if (run && slot_free_s) begin
               ir_d       = rom_inst;
               ir_pc_d    = pc_q;
               ir_valid_d = 1'b1;
               if ((pc_q == PC_LAST) && STOP_AT_END) begin
                  state_d  = S_HALT;
                  halted_d = 1'b1;
               end else begin
                  pc_d = pc_q + PC_ONE;
               end
            end else if (transfer_s) begin
               // Not fetching: just drain the consumed instruction.
               ir_valid_d = 1'b0;
            end else begin
               ir_valid_d = ir_valid_q;
            end
         end
         S_HALT: begin
            if (redir_valid) begin
               pc_d       = redir_addr;
               ir_valid_d = 1'b0;
               halted_d   = 1'b0;
               state_d    = S_FETCH;
            end else if (transfer_s) begin
               ir_valid_d = 1'b0;
            end else begin
               ir_valid_d = ir_valid_q;
            end
         end
         default: begin
            state_d    = S_FETCH;
            ir_valid_d = 1'b0;
            halted_d   = 1'b0;
         end
      endcase
   end

   assign rom_addr = pc_q;
   assign ir       = ir_q;
   assign ir_pc    = ir_pc_q;
   assign ir_valid = ir_valid_q;
   assign halted   = halted_q;

endmodule
